// File: rtl/ps2_key_fifo.sv
// PS/2 key word -> 2048 game command decoder with a show-ahead command FIFO polled over MIO_BUS.
// Latency: ps2_ready sampled at edge N+1 -> entry visible after edge N+2. Optional PS2_TYPEMATIC_FILTER_EN drops auto-repeats.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module ps2_key_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_ready,
  input  logic [9:0]  ps2_key,
  input  logic        rd_en,
  input  logic        clr,
  output logic        key_valid,
  output logic [2:0]  key_code,
  output logic        overflow,
  output logic [31:0] bus_word
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Arrow/WASD keys map regardless of the E0 prefix; only R requires a plain scan code.
  function automatic logic [2:0] decode(input logic ext, input logic [7:0] scan);
    logic [2:0] c;
    c = 3'd0;
    case (scan)
      8'h1D, 8'h75: c = 3'd1;
      8'h1B, 8'h72: c = 3'd2;
      8'h1C, 8'h6B: c = 3'd3;
      8'h23, 8'h74: c = 3'd4;
      8'h2D:        c = ext ? 3'd0 : 3'd5;
      default:      c = 3'd0;
    endcase
    return c;
  endfunction

  logic [2:0]        dec_code;
  logic              dec_brk;
  logic              dec_vld;
  logic [2:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              filter_ok;
  logic              push_req;
  logic              do_push;
  logic              do_pop;
  logic [7:0]        count8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_code <= 3'd0;
      dec_brk  <= 1'b0;
      dec_vld  <= 1'b0;
    end else if (clr) begin
      dec_vld  <= 1'b0;
    end else begin
      dec_vld <= ps2_ready;
      if (ps2_ready) begin
        dec_code <= decode(ps2_key[9], ps2_key[7:0]);
        dec_brk  <= ps2_key[8];
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] held;

  assign filter_ok = ~held[dec_code];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 8'd0;
    end else if (clr) begin
      held <= 8'd0;
    end else if (dec_vld && dec_code != 3'd0) begin
      held[dec_code] <= ~dec_brk;
    end
  end
`else
  assign filter_ok = 1'b1;
`endif

  assign full      = (count == FULL_CNT);
  assign key_valid = (count != '0);
  assign push_req  = dec_vld & ~dec_brk & (dec_code != 3'd0) & filter_ok;
  assign do_pop    = rd_en & key_valid;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign do_push   = push_req & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (push_req && full && !do_pop) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= dec_code;
  end

  assign key_code = key_valid ? mem[rd_ptr] : 3'd0;
  assign count8   = 8'(count);
  assign bus_word = {key_valid, overflow, 6'b0, count8, 13'b0, key_code};

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: decode table vectors plus multi-cycle FIFO corner sequences.
module tb_ps2_key_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_ready;
  logic [9:0]  ps2_key;
  logic        rd_en;
  logic        clr;
  logic        key_valid;
  logic [2:0]  key_code;
  logic        overflow;
  logic [31:0] bus_word;

  int total = 0;
  int bad   = 0;

`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int TYPEMATIC_CNT = 2;
`else
  localparam int TYPEMATIC_CNT = 4;
`endif

  typedef struct {
    logic [9:0] key;
    logic [2:0] code;
  } vec_t;

  vec_t vecs [14];

  ps2_key_fifo #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_ready (ps2_ready),
    .ps2_key   (ps2_key),
    .rd_en     (rd_en),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .overflow  (overflow),
    .bus_word  (bus_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe one key word and wait until it has reached the FIFO.
  task automatic send(input logic [9:0] k);
    ps2_ready = 1'b1;
    ps2_key   = k;
    cyc();
    ps2_ready = 1'b0;
    cyc();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'h01D, 3'd1};
    vecs[1]  = '{10'h075, 3'd1};
    vecs[2]  = '{10'h275, 3'd1};
    vecs[3]  = '{10'h01B, 3'd2};
    vecs[4]  = '{10'h272, 3'd2};
    vecs[5]  = '{10'h01C, 3'd3};
    vecs[6]  = '{10'h26B, 3'd3};
    vecs[7]  = '{10'h023, 3'd4};
    vecs[8]  = '{10'h274, 3'd4};
    vecs[9]  = '{10'h02D, 3'd5};
    vecs[10] = '{10'h22D, 3'd0};
    vecs[11] = '{10'h034, 3'd0};
    vecs[12] = '{10'h11D, 3'd0};
    vecs[13] = '{10'h000, 3'd0};

    rst = 1'b1; ps2_ready = 1'b0; ps2_key = '0; rd_en = 1'b0; clr = 1'b0;
    cyc();
    cyc();
    check("reset_bus_word", bus_word, 32'h0);
    rst = 1'b0;
    cyc();
    check("post_reset_bus_word", bus_word, 32'h0);

    // Decode table
    for (int i = 0; i < 14; i++) begin
      do_clr();
      send(vecs[i].key);
      check($sformatf("vec%0d_valid", i), {31'b0, key_valid}, {31'b0, vecs[i].code != 3'd0});
      check($sformatf("vec%0d_code", i), {29'b0, key_code}, {29'b0, vecs[i].code});
      check($sformatf("vec%0d_count", i), {24'b0, bus_word[23:16]}, (vecs[i].code != 3'd0) ? 32'd1 : 32'd0);
    end

    // Async reset mid-traffic
    do_clr();
    send(10'h01D);
    send(10'h01B);
    check("pre_rst_count", {24'b0, bus_word[23:16]}, 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_bus_word", bus_word, 32'h0);
    cyc();
    check("rst_high_bus_word", bus_word, 32'h0);
    rst = 1'b0;
    cyc();
    check("rst_after_bus_word", bus_word, 32'h0);
    send(10'h01D);
    check("rst_first_key", {29'b0, key_code}, 32'd1);

    // Single key latency
    do_clr();
    ps2_ready = 1'b1;
    ps2_key   = 10'h075;
    cyc();
    ps2_ready = 1'b0;
    check("latency_n1_valid", {31'b0, key_valid}, 32'd0);
    cyc();
    check("single_bus_word", bus_word, 32'h8001_0001);

    // Make then break of A, then unmapped key
    do_clr();
    send(10'h01C);
    send(10'h11C);
    check("make_brk_count", {24'b0, bus_word[23:16]}, 32'd1);
    check("make_brk_code", {29'b0, key_code}, 32'd3);
    do_clr();
    send(10'h034);
    check("unmapped_bus_word", bus_word, 32'h0);

    // Back-to-back strobes: both words must be processed
    do_clr();
    ps2_ready = 1'b1; ps2_key = 10'h01D;
    cyc();
    ps2_key = 10'h01B;
    cyc();
    ps2_ready = 1'b0;
    cyc();
    check("b2b_count", {24'b0, bus_word[23:16]}, 32'd2);
    check("b2b_head", {29'b0, key_code}, 32'd1);
    pop();
    check("b2b_second", {29'b0, key_code}, 32'd2);

    // Push and pop on an empty FIFO: pop ignored
    do_clr();
    ps2_ready = 1'b1; ps2_key = 10'h01C;
    cyc();
    ps2_ready = 1'b0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("empty_pushpop_bus_word", bus_word, 32'h8001_0003);

    // Typematic repeats
    do_clr();
    send(10'h023);
    send(10'h023);
    send(10'h023);
    send(10'h123);
    send(10'h023);
    check("typematic_count", {24'b0, bus_word[23:16]}, TYPEMATIC_CNT);
    for (int i = 0; i < TYPEMATIC_CNT; i++) begin
      check($sformatf("typematic_code%0d", i), {29'b0, key_code}, 32'd4);
      pop();
    end
    check("typematic_drained", {31'b0, key_valid}, 32'd0);

    // Overflow
    do_clr();
    send(10'h01D);
    send(10'h01B);
    send(10'h01C);
    send(10'h023);
    check("ovf_before", {31'b0, overflow}, 32'd0);
    send(10'h02D);
    check("ovf_bus_word", bus_word, 32'hC004_0001);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d_code", i), {29'b0, key_code}, i + 1);
      pop();
      check($sformatf("ovf_pop%0d_sticky", i), {31'b0, overflow}, 32'd1);
    end
    check("ovf_drained_bus_word", bus_word, 32'h4000_0000);
    do_clr();
    check("ovf_clr_bus_word", bus_word, 32'h0);

    // Full FIFO with simultaneous push and pop
    send(10'h01D);
    send(10'h01B);
    send(10'h01C);
    send(10'h023);
    ps2_ready = 1'b1; ps2_key = 10'h02D;
    cyc();
    ps2_ready = 1'b0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("sim_bus_word", bus_word, 32'h8004_0002);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sim_pop%0d_code", i), {29'b0, key_code}, i + 2);
      pop();
    end
    check("sim_tail_bus_word", bus_word, 32'h8001_0005);

    // clr wins over a concurrent push
    send(10'h11B);
    ps2_ready = 1'b1; ps2_key = 10'h01B;
    cyc();
    ps2_ready = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_push_bus_word", bus_word, 32'h0);
    cyc();
    check("clr_push_settled", bus_word, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
